// File: rtl/vproc_cfg_unit.sv
`default_nettype none
// ============================================================================
// Module   : vproc_cfg_unit
// Purpose  : Vector configuration unit. Executes vsetvl/vsetvli/vsetivli and
//            the vector CSR accesses (vtype, vl, vlenb, vstart, vxsat, vxrm,
//            vcsr). Holds the architectural vector configuration, broadcasts
//            it to the execution units and returns the scalar write-back value.
//            Every state-changing operation first waits for all in-flight
//            vector instructions to drain.
//
// Ports    : clk_i / sync_rst_i       clock, synchronous active-high reset
//            req_valid_i / req_ready_o request handshake
//            req_mode_i [12:0]         packed operation descriptor:
//                                        [12:9] csr_op  [8:7] vsew
//                                        [6:4]  lmul    [3:2] agnostic {vma,vta}
//                                        [1]    vlmax   [0]   keep_vl
//            req_xval_i [31:0]         AVL or CSR source operand
//            req_id_i                  instruction ID
//            units_busy_i              any vector instruction in flight
//            vxsat_set_i               a unit saturated, sets vxsat
//            res_valid_o / res_ready_i result handshake
//            res_id_o, res_xval_o      result ID and scalar write-back value
//            vsew_o, lmul_o, agnostic_o, vill_o, vl_o, vl_0_o,
//            vstart_o, vxrm_o, vxsat_o  registered vector configuration
//
//            csr_op : 0 VSETVL, 1 VTYPE_READ, 2 VL_READ, 3 VLENB_READ,
//                     4/5/6 VSTART_WRITE/SET/CLEAR, 7/8/9 VXSAT_WRITE/SET/CLEAR,
//                     10/11/12 VXRM_WRITE/SET/CLEAR, 13/14/15 VCSR_WRITE/SET/CLEAR
//            vsew   : 0 SEW8, 1 SEW16, 2 SEW32, 3 INVALID
//            lmul   : 0 M1, 1 M2, 2 M4, 3 M8, 4 INVALID, 5 F8, 6 F4, 7 F2
//            vxrm   : 0 RNU, 1 RNE, 2 RDN, 3 ROD
//
// Revision : 1.0  initial release
// ============================================================================
module vproc_cfg_unit #(
   parameter int unsigned VREG_W = 128,
   parameter int unsigned ID_W   = 3
) (
   input  logic                      clk_i,
   input  logic                      sync_rst_i,
   input  logic                      req_valid_i,
   output logic                      req_ready_o,
   input  logic [12:0]               req_mode_i,
   input  logic [31:0]               req_xval_i,
   input  logic [ID_W-1:0]           req_id_i,
   input  logic                      units_busy_i,
   input  logic                      vxsat_set_i,
   output logic                      res_valid_o,
   input  logic                      res_ready_i,
   output logic [ID_W-1:0]           res_id_o,
   output logic [31:0]               res_xval_o,
   output logic [1:0]                vsew_o,
   output logic [2:0]                lmul_o,
   output logic [1:0]                agnostic_o,
   output logic                      vill_o,
   output logic [$clog2(VREG_W):0]   vl_o,
   output logic                      vl_0_o,
   output logic [$clog2(VREG_W)-1:0] vstart_o,
   output logic [1:0]                vxrm_o,
   output logic                      vxsat_o
);

   localparam int unsigned c_VL_W = $clog2(VREG_W) + 1;
   localparam int unsigned c_VS_W = $clog2(VREG_W);

   // operation codes
   localparam logic [3:0] c_OP_VSETVL       = 4'd0;
   localparam logic [3:0] c_OP_VTYPE_READ   = 4'd1;
   localparam logic [3:0] c_OP_VL_READ      = 4'd2;
   localparam logic [3:0] c_OP_VLENB_READ   = 4'd3;
   localparam logic [3:0] c_OP_VSTART_WRITE = 4'd4;
   localparam logic [3:0] c_OP_VSTART_SET   = 4'd5;
   localparam logic [3:0] c_OP_VSTART_CLEAR = 4'd6;
   localparam logic [3:0] c_OP_VXSAT_WRITE  = 4'd7;
   localparam logic [3:0] c_OP_VXSAT_SET    = 4'd8;
   localparam logic [3:0] c_OP_VXSAT_CLEAR  = 4'd9;
   localparam logic [3:0] c_OP_VXRM_WRITE   = 4'd10;
   localparam logic [3:0] c_OP_VXRM_SET     = 4'd11;
   localparam logic [3:0] c_OP_VXRM_CLEAR   = 4'd12;
   localparam logic [3:0] c_OP_VCSR_WRITE   = 4'd13;
   localparam logic [3:0] c_OP_VCSR_SET     = 4'd14;
   localparam logic [3:0] c_OP_VCSR_CLEAR   = 4'd15;

   localparam logic [1:0] c_VSEW_8       = 2'd0;
   localparam logic [1:0] c_VSEW_32      = 2'd2;
   localparam logic [1:0] c_VSEW_INVALID = 2'd3;

   localparam logic [2:0] c_LMUL_1       = 3'd0;
   localparam logic [2:0] c_LMUL_2       = 3'd1;
   localparam logic [2:0] c_LMUL_4       = 3'd2;
   localparam logic [2:0] c_LMUL_8       = 3'd3;
   localparam logic [2:0] c_LMUL_INVALID = 3'd4;
   localparam logic [2:0] c_LMUL_F8      = 3'd5;
   localparam logic [2:0] c_LMUL_F4      = 3'd6;
   localparam logic [2:0] c_LMUL_F2      = 3'd7;

   localparam logic [1:0] c_VXRM_RNU = 2'd0;

   // CSR access target and kind
   localparam logic [2:0] c_TGT_NONE   = 3'd0;
   localparam logic [2:0] c_TGT_VSTART = 3'd1;
   localparam logic [2:0] c_TGT_VXSAT  = 3'd2;
   localparam logic [2:0] c_TGT_VXRM   = 3'd3;
   localparam logic [2:0] c_TGT_VCSR   = 3'd4;

   localparam logic [1:0] c_KIND_NONE  = 2'd0;
   localparam logic [1:0] c_KIND_WRITE = 2'd1;
   localparam logic [1:0] c_KIND_SET   = 2'd2;
   localparam logic [1:0] c_KIND_CLEAR = 2'd3;

   // FSM states
   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_DRAIN = 2'd1;
   localparam logic [1:0] c_ST_CALC  = 2'd2;
   localparam logic [1:0] c_ST_RESP  = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;

   logic [12:0]       r_mode;
   logic [31:0]       r_xval;
   logic [ID_W-1:0]   r_id;

   logic [1:0]        r_vsew;
   logic [2:0]        r_lmul;
   logic [1:0]        r_agnostic;
   logic              r_vill;
   logic [c_VL_W-1:0] r_vl;
   logic [c_VS_W-1:0] r_vstart;
   logic [1:0]        r_vxrm;
   logic              r_vxsat;
   logic [ID_W-1:0]   r_res_id;
   logic [31:0]       r_res_xval;

   logic              w_accept;
   logic              w_req_is_read;
   logic              w_calc;

   logic [3:0]        w_op;
   logic [1:0]        w_vsew;
   logic [2:0]        w_lmul;
   logic [1:0]        w_agnostic;
   logic              w_vlmax_flag;
   logic              w_keep_vl;

   logic [c_VL_W-1:0] w_vlmax_base;
   logic [c_VL_W-1:0] w_vlmax;
   logic              w_vill;
   logic [c_VL_W-1:0] w_new_vl;

   logic [2:0]        w_tgt;
   logic [1:0]        w_kind;
   logic [31:0]       w_old;
   logic [c_VS_W-1:0] w_old_t;
   logic [c_VS_W-1:0] w_xval_t;
   logic [c_VS_W-1:0] w_upd;
   logic              w_vxsat_upd;
   logic [31:0]       w_result;

   // ------------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_state <= c_ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_req_is_read = (req_mode_i[12:9] == c_OP_VTYPE_READ) |
                          (req_mode_i[12:9] == c_OP_VL_READ)    |
                          (req_mode_i[12:9] == c_OP_VLENB_READ);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = w_req_is_read ? c_ST_CALC : c_ST_DRAIN;
            end
         end
         c_ST_DRAIN: begin
            if (!units_busy_i) begin
               w_state_nxt = c_ST_CALC;
            end
         end
         c_ST_CALC: w_state_nxt = c_ST_RESP;
         c_ST_RESP: begin
            if (res_ready_i) begin
               w_state_nxt = c_ST_IDLE;
            end
         end
         default:   w_state_nxt = c_ST_IDLE;
      endcase
   end

   // ready is masked by reset so nothing is accepted while reset is held
   always_comb begin
      req_ready_o = 1'b0;
      res_valid_o = 1'b0;
      case (r_state)
         c_ST_IDLE: req_ready_o = ~sync_rst_i;
         c_ST_RESP: res_valid_o = 1'b1;
         default:   ;
      endcase
   end

   assign w_accept = req_valid_i & req_ready_o;
   assign w_calc   = (r_state == c_ST_CALC);

   // ------------------------------------------------------------------------
   // Request capture
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_mode <= '0;
         r_xval <= '0;
         r_id   <= '0;
      end else if (w_accept) begin
         r_mode <= req_mode_i;
         r_xval <= req_xval_i;
         r_id   <= req_id_i;
      end
   end

   assign w_op         = r_mode[12:9];
   assign w_vsew       = r_mode[8:7];
   assign w_lmul       = r_mode[6:4];
   assign w_agnostic   = r_mode[3:2];
   assign w_vlmax_flag = r_mode[1];
   assign w_keep_vl    = r_mode[0];

   // ------------------------------------------------------------------------
   // vsetvl: VLMAX, vill and new vl
   // ------------------------------------------------------------------------
   always_comb begin
      // elements per register at LMUL=1; the invalid SEW value is never used
      w_vlmax_base = c_VL_W'(VREG_W / 8) >> w_vsew;
      case (w_lmul)
         c_LMUL_1: w_vlmax = w_vlmax_base;
         c_LMUL_2: w_vlmax = w_vlmax_base << 1;
         c_LMUL_4: w_vlmax = w_vlmax_base << 2;
         c_LMUL_8: w_vlmax = w_vlmax_base << 3;
         c_LMUL_F2: w_vlmax = w_vlmax_base >> 1;
         c_LMUL_F4: w_vlmax = w_vlmax_base >> 2;
         c_LMUL_F8: w_vlmax = w_vlmax_base >> 3;
         default:   w_vlmax = w_vlmax_base;
      endcase
   end

   assign w_vill = (w_vsew == c_VSEW_INVALID) |
                   (w_lmul == c_LMUL_INVALID) |
                   (w_lmul == c_LMUL_F8) |
                   ((w_lmul == c_LMUL_F4) & (w_vsew != c_VSEW_8)) |
                   ((w_lmul == c_LMUL_F2) & (w_vsew == c_VSEW_32));

   always_comb begin
      if (w_vill) begin
         w_new_vl = '0;
      end else if (w_vlmax_flag) begin
         w_new_vl = w_vlmax;
      end else if (w_keep_vl) begin
         w_new_vl = (r_vl < w_vlmax) ? r_vl : w_vlmax;
      end else begin
         // AVL is compared at full 32-bit width before narrowing
         w_new_vl = (r_xval < 32'(w_vlmax)) ? r_xval[c_VL_W-1:0] : w_vlmax;
      end
   end

   // ------------------------------------------------------------------------
   // CSR write/set/clear
   // ------------------------------------------------------------------------
   always_comb begin
      w_tgt  = c_TGT_NONE;
      w_kind = c_KIND_NONE;
      case (w_op)
         c_OP_VSTART_WRITE: begin w_tgt = c_TGT_VSTART; w_kind = c_KIND_WRITE; end
         c_OP_VSTART_SET:   begin w_tgt = c_TGT_VSTART; w_kind = c_KIND_SET;   end
         c_OP_VSTART_CLEAR: begin w_tgt = c_TGT_VSTART; w_kind = c_KIND_CLEAR; end
         c_OP_VXSAT_WRITE:  begin w_tgt = c_TGT_VXSAT;  w_kind = c_KIND_WRITE; end
         c_OP_VXSAT_SET:    begin w_tgt = c_TGT_VXSAT;  w_kind = c_KIND_SET;   end
         c_OP_VXSAT_CLEAR:  begin w_tgt = c_TGT_VXSAT;  w_kind = c_KIND_CLEAR; end
         c_OP_VXRM_WRITE:   begin w_tgt = c_TGT_VXRM;   w_kind = c_KIND_WRITE; end
         c_OP_VXRM_SET:     begin w_tgt = c_TGT_VXRM;   w_kind = c_KIND_SET;   end
         c_OP_VXRM_CLEAR:   begin w_tgt = c_TGT_VXRM;   w_kind = c_KIND_CLEAR; end
         c_OP_VCSR_WRITE:   begin w_tgt = c_TGT_VCSR;   w_kind = c_KIND_WRITE; end
         c_OP_VCSR_SET:     begin w_tgt = c_TGT_VCSR;   w_kind = c_KIND_SET;   end
         c_OP_VCSR_CLEAR:   begin w_tgt = c_TGT_VCSR;   w_kind = c_KIND_CLEAR; end
         default:           ;
      endcase
   end

   always_comb begin
      case (w_tgt)
         c_TGT_VSTART: w_old = 32'(r_vstart);
         c_TGT_VXSAT:  w_old = 32'(r_vxsat);
         c_TGT_VXRM:   w_old = 32'(r_vxrm);
         c_TGT_VCSR:   w_old = 32'({r_vxrm, r_vxsat});
         default:      w_old = '0;
      endcase
   end

   // vstart is the widest CSR target, so the update is done at its width and
   // narrower targets take their low bits
   assign w_old_t  = w_old[c_VS_W-1:0];
   assign w_xval_t = r_xval[c_VS_W-1:0];

   always_comb begin
      case (w_kind)
         c_KIND_WRITE: w_upd = w_xval_t;
         c_KIND_SET:   w_upd = w_old_t | w_xval_t;
         c_KIND_CLEAR: w_upd = w_old_t & ~w_xval_t;
         default:      w_upd = w_old_t;
      endcase
   end

   assign w_vxsat_upd = w_calc & ((w_tgt == c_TGT_VXSAT) | (w_tgt == c_TGT_VCSR));

   // ------------------------------------------------------------------------
   // Scalar result
   // ------------------------------------------------------------------------
   always_comb begin
      case (w_op)
         c_OP_VSETVL:     w_result = 32'(w_new_vl);
         // an illegal vtype reads back as vill alone, all other fields zero
         c_OP_VTYPE_READ: w_result = r_vill ? 32'h8000_0000 :
                                     {1'b0, 23'b0, r_agnostic, 1'b0, r_vsew, r_lmul};
         c_OP_VL_READ:    w_result = 32'(r_vl);
         c_OP_VLENB_READ: w_result = 32'(VREG_W / 8);
         default:         w_result = w_old;
      endcase
   end

   // ------------------------------------------------------------------------
   // Architectural configuration and result registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (sync_rst_i) begin
         r_vsew     <= c_VSEW_8;
         r_lmul     <= c_LMUL_1;
         r_agnostic <= '0;
         r_vill     <= 1'b1;
         r_vl       <= '0;
         r_vstart   <= '0;
         r_vxrm     <= c_VXRM_RNU;
         r_vxsat    <= 1'b0;
         r_res_id   <= '0;
         r_res_xval <= '0;
      end else begin
         // a saturation report is never lost, even during a vxsat update
         r_vxsat <= (w_vxsat_upd ? w_upd[0] : r_vxsat) | vxsat_set_i;
         if (w_calc) begin
            r_res_id   <= r_id;
            r_res_xval <= w_result;
            if (w_op == c_OP_VSETVL) begin
               r_vsew     <= w_vsew;
               r_lmul     <= w_lmul;
               r_agnostic <= w_agnostic;
               r_vill     <= w_vill;
               r_vl       <= w_new_vl;
            end
            case (w_tgt)
               c_TGT_VSTART: r_vstart <= w_upd;
               c_TGT_VXRM:   r_vxrm   <= w_upd[1:0];
               c_TGT_VCSR:   r_vxrm   <= w_upd[2:1];
               default:      ;
            endcase
         end
      end
   end

   assign res_id_o   = r_res_id;
   assign res_xval_o = r_res_xval;
   assign vsew_o     = r_vsew;
   assign lmul_o     = r_lmul;
   assign agnostic_o = r_agnostic;
   assign vill_o     = r_vill;
   assign vl_o       = r_vl;
   assign vl_0_o     = (r_vl == '0);
   assign vstart_o   = r_vstart;
   assign vxrm_o     = r_vxrm;
   assign vxsat_o    = r_vxsat;

endmodule
`default_nettype wire
